// File: rtl/priority_service_sched.sv
// priority_service_sched: one shared service resource granted to one
// customer at a time, for a fixed window of SERVICE_CYCLES clocks.
// Three classes: VVIP (single waiting slot), VIP and normal (saturating
// counters). Strict priority VVIP > VIP > normal.
// Optional build macro STARVE_GUARD_EN adds an age counter that lets a
// waiting normal customer win over VIP after AGE_LIMIT consecutive VIP grants.
module priority_service_sched #(
  parameter int SERVICE_CYCLES = 4,
  parameter int NP_W           = 32,
  parameter int VIP_W          = 8,
  parameter int AGE_LIMIT      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             np_arrive,
  input  logic             vip_arrive,
  input  logic             vvip_arrive,
  output logic [2:0]       grant,
  output logic             busy,
  output logic             svc_done,
  output logic [NP_W-1:0]  np_cnt,
  output logic [VIP_W-1:0] vip_cnt,
  output logic             vvip_pend,
  output logic             drop
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  // Timer counts the remaining hold edges of the current window; 0 marks
  // the completion edge.
  localparam logic [7:0] TIMER_LOAD = 8'(SERVICE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       timer;
  logic [7:0]       timer_nxt;
  logic [2:0]       grant_nxt;
  logic             svc_done_nxt;

  logic             pend_any;
  logic             sel_point;
  logic             pick_vvip;
  logic             pick_vip;
  logic             pick_np;
  logic             np_guard_hit;
  logic             take_np;
  logic             take_vip;
  logic             take_vvip;

  logic [NP_W-1:0]  np_cnt_nxt;
  logic [VIP_W-1:0] vip_cnt_nxt;
  logic             vvip_pend_nxt;
  logic             np_drop;
  logic             vip_drop;
  logic             vvip_drop;

  // Saturating pending-count update for the normal class.
  // Returns {lost_arrival, next_count}.
  function automatic logic [NP_W:0] np_step(input logic [NP_W-1:0] cnt,
                                            input logic            arr,
                                            input logic            tk);
    logic [NP_W:0] r;
    r = {1'b0, cnt};
    if (arr && !tk) begin
      if (&cnt) r[NP_W] = 1'b1;
      else      r = {1'b0, cnt + NP_W'(1)};
    end else if (!arr && tk) begin
      r = {1'b0, cnt - NP_W'(1)};
    end
    return r;
  endfunction

  // Saturating pending-count update for the VIP class.
  // Returns {lost_arrival, next_count}.
  function automatic logic [VIP_W:0] vip_step(input logic [VIP_W-1:0] cnt,
                                              input logic             arr,
                                              input logic             tk);
    logic [VIP_W:0] r;
    r = {1'b0, cnt};
    if (arr && !tk) begin
      if (&cnt) r[VIP_W] = 1'b1;
      else      r = {1'b0, cnt + VIP_W'(1)};
    end else if (!arr && tk) begin
      r = {1'b0, cnt - VIP_W'(1)};
    end
    return r;
  endfunction

`ifdef STARVE_GUARD_EN
  localparam logic [3:0] AGE_LIM4 = 4'(AGE_LIMIT);

  logic [3:0] age;
  logic [3:0] age_nxt;

  assign np_guard_hit = (np_cnt != '0) && (age == AGE_LIM4);

  // Age tracks consecutive VIP selections made while a normal customer waits.
  always_comb begin
    age_nxt = age;
    if (np_cnt == '0)  age_nxt = 4'd0;
    else if (take_np)  age_nxt = 4'd0;
    else if (take_vip) age_nxt = age + 4'd1;
  end

  // Age register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age <= 4'd0;
    else        age <= age_nxt;
  end
`else
  // Without the guard the age limit has no effect; the parameter stays so
  // both builds share one instantiation signature.
  logic [3:0] unused_age_limit;
  assign unused_age_limit = 4'(AGE_LIMIT);
  assign np_guard_hit     = 1'b0;
`endif

  // Class selection from the registered counts.
  always_comb begin
    pick_vvip = 1'b0;
    pick_vip  = 1'b0;
    pick_np   = 1'b0;
    if (vvip_pend) begin
      pick_vvip = 1'b1;
    end else if (vip_cnt != '0) begin
      if (np_guard_hit) pick_np  = 1'b1;
      else              pick_vip = 1'b1;
    end else if (np_cnt != '0) begin
      pick_np = 1'b1;
    end
  end

  assign pend_any  = vvip_pend | (vip_cnt != '0) | (np_cnt != '0);
  // A new customer can be taken when idle or on a window's completion edge.
  assign sel_point = (state == IDLE) || (timer == 8'd0);
  assign take_vvip = sel_point & pick_vvip;
  assign take_vip  = sel_point & pick_vip;
  assign take_np   = sel_point & pick_np;

  assign {np_drop, np_cnt_nxt}   = np_step(np_cnt, np_arrive, take_np);
  assign {vip_drop, vip_cnt_nxt} = vip_step(vip_cnt, vip_arrive, take_vip);
  assign vvip_drop     = vvip_arrive & vvip_pend & ~take_vvip;
  assign vvip_pend_nxt = (vvip_pend & ~take_vvip) | vvip_arrive;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_any) state_nxt = SERVE;
      SERVE:   if ((timer == 8'd0) && !pend_any) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: grant, window timer and completion pulse.
  always_comb begin
    grant_nxt    = grant;
    timer_nxt    = timer;
    svc_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pend_any) begin
          grant_nxt = {pick_vvip, pick_vip, pick_np};
          timer_nxt = TIMER_LOAD;
        end
      end
      SERVE: begin
        if (timer != 8'd0) begin
          timer_nxt = timer - 8'd1;
        end else begin
          svc_done_nxt = 1'b1;
          if (pend_any) begin
            grant_nxt = {pick_vvip, pick_vip, pick_np};
            timer_nxt = TIMER_LOAD;
          end else begin
            grant_nxt = 3'b000;
          end
        end
      end
      default: begin
        grant_nxt = 3'b000;
        timer_nxt = 8'd0;
      end
    endcase
  end

  // Registered outputs, pending counts and window timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= 8'd0;
      grant     <= 3'b000;
      busy      <= 1'b0;
      svc_done  <= 1'b0;
      np_cnt    <= '0;
      vip_cnt   <= '0;
      vvip_pend <= 1'b0;
      drop      <= 1'b0;
    end else begin
      timer     <= timer_nxt;
      grant     <= grant_nxt;
      busy      <= (grant_nxt != 3'b000);
      svc_done  <= svc_done_nxt;
      np_cnt    <= np_cnt_nxt;
      vip_cnt   <= vip_cnt_nxt;
      vvip_pend <= vvip_pend_nxt;
      drop      <= np_drop | vip_drop | vvip_drop;
    end
  end

endmodule

// File: tb/tb_priority_service_sched.sv
// Testbench for priority_service_sched: vector table, directed corner
// sequences and randomized arrivals checked against a behavioural model.
// Build with STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_priority_service_sched;

  localparam int SC     = 4;
  localparam int NPW    = 2;
  localparam int VIPW   = 2;
  localparam int AGEL   = 3;
  localparam int NPMAX  = (1 << NPW) - 1;
  localparam int VIPMAX = (1 << VIPW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            np_arrive = 1'b0;
  logic            vip_arrive = 1'b0;
  logic            vvip_arrive = 1'b0;
  logic [2:0]      grant;
  logic            busy;
  logic            svc_done;
  logic [NPW-1:0]  np_cnt;
  logic [VIPW-1:0] vip_cnt;
  logic            vvip_pend;
  logic            drop;
  logic [11:0]     dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  priority_service_sched #(
    .SERVICE_CYCLES(SC),
    .NP_W(NPW),
    .VIP_W(VIPW),
    .AGE_LIMIT(AGEL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .np_arrive(np_arrive),
    .vip_arrive(vip_arrive),
    .vvip_arrive(vvip_arrive),
    .grant(grant),
    .busy(busy),
    .svc_done(svc_done),
    .np_cnt(np_cnt),
    .vip_cnt(vip_cnt),
    .vvip_pend(vvip_pend),
    .drop(drop)
  );

  always #5 clk = ~clk;

  assign dut_vec = {grant, busy, svc_done, np_cnt, vip_cnt, vvip_pend, drop};

  // Behavioural model: queue lengths as integers, the customer in service
  // as a class code plus the number of cycles it still holds the resource.
  int m_np, m_vip, m_cls, m_left, m_age;
  bit m_vv, m_done, m_drop;

  task automatic model_reset();
    m_np = 0; m_vip = 0; m_vv = 0; m_cls = 0; m_left = 0;
    m_age = 0; m_done = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit a_np, input bit a_vip, input bit a_vv);
    int sel;
    int n;
    bit done;
    sel  = 0;
    done = 0;
    if (m_cls != 0 && m_left > 1) begin
      m_left = m_left - 1;
    end else begin
      done = (m_cls != 0);
      if (m_vv) sel = 4;
      else if (m_vip > 0) begin
        sel = 2;
`ifdef STARVE_GUARD_EN
        if (m_np > 0 && m_age == AGEL) sel = 1;
`endif
      end else if (m_np > 0) sel = 1;
      m_cls  = sel;
      m_left = SC;
    end
`ifdef STARVE_GUARD_EN
    if (m_np == 0)     m_age = 0;
    else if (sel == 1) m_age = 0;
    else if (sel == 2) m_age = m_age + 1;
`endif
    m_drop = 0;
    n = m_np + int'(a_np) - ((sel == 1) ? 1 : 0);
    if (n > NPMAX) begin n = NPMAX; m_drop = 1; end
    m_np = n;
    n = m_vip + int'(a_vip) - ((sel == 2) ? 1 : 0);
    if (n > VIPMAX) begin n = VIPMAX; m_drop = 1; end
    m_vip = n;
    if (a_vv && m_vv && sel != 4) m_drop = 1;
    m_vv   = (m_vv && sel != 4) || a_vv;
    m_done = done;
  endtask

  function automatic logic [11:0] model_vec();
    return {3'(m_cls), (m_cls != 0), m_done, NPW'(m_np), VIPW'(m_vip), m_vv, m_drop};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive arrivals {vvip,vip,np}, advance DUT and model, compare.
  task automatic tick(input logic [2:0] arr);
    {vvip_arrive, vip_arrive, np_arrive} = arr;
    @(posedge clk);
    model_step(arr[0], arr[1], arr[2]);
    #1;
    chk("model", 32'(dut_vec), 32'(model_vec()));
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic do_reset();
    {vvip_arrive, vip_arrive, np_arrive} = 3'b000;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst", 32'(dut_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_cls != 0 || m_np != 0 || m_vip != 0 || m_vv) && k < 200) begin
      tick(3'b000);
      k++;
    end
    chk("drain_idle", 32'({grant, np_cnt, vip_cnt, vvip_pend}), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  arr;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] arr, input logic [2:0] g, input logic b,
                     input logic d, input logic [1:0] np, input logic [1:0] vip,
                     input logic vv, input logic dr);
    vec_t v;
    v.arr = arr;
    v.exp = {g, b, d, np, vip, vv, dr};
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp5[5];
    int npg;
    logic [2:0] arr;

    // Priority/window table: all three classes arrive together.
    add(3'b111, 3'b000, 0, 0, 2'd1, 2'd1, 1, 0);
    add(3'b000, 3'b100, 1, 0, 2'd1, 2'd1, 0, 0);
    for (int i = 0; i < 3; i++) add(3'b000, 3'b100, 1, 0, 2'd1, 2'd1, 0, 0);
    add(3'b000, 3'b010, 1, 1, 2'd1, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) add(3'b000, 3'b010, 1, 0, 2'd1, 2'd0, 0, 0);
    add(3'b000, 3'b001, 1, 1, 2'd0, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) add(3'b000, 3'b001, 1, 0, 2'd0, 2'd0, 0, 0);
    add(3'b000, 3'b000, 0, 1, 2'd0, 2'd0, 0, 0);
    add(3'b000, 3'b000, 0, 0, 2'd0, 2'd0, 0, 0);

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(dut_vec), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].arr);
      chk("tbl", 32'(dut_vec), 32'(tbl[i].exp));
    end

    // Single normal arrival: granted two cycles later, then back to idle.
    tick(3'b001);
    chk("idle_np_cnt", 32'(np_cnt), 32'd1);
    chk("idle_no_grant_yet", 32'(grant), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(3'b000);
      chk("idle_np_grant", 32'(grant), 32'b001);
    end
    tick(3'b000);
    chk("idle_ret_grant", 32'(grant), 32'd0);
    chk("idle_ret_busy", 32'(busy), 32'd0);
    chk("idle_ret_done", 32'(svc_done), 32'd1);

    // Back-to-back VIP with an arrival on the completion edge.
    tick(3'b010);
    for (int g = 1; g <= 13; g++) begin
      tick((g == 1 || g == 5) ? 3'b010 : 3'b000);
      if (g <= 12) chk("b2b_busy", 32'(busy), 32'd1);
      if (g == 1) chk("b2b_vip_cnt1", 32'(vip_cnt), 32'd1);
      if (g == 5 || g == 9) begin
        chk("b2b_grant", 32'(grant), 32'b010);
        chk("b2b_done", 32'(svc_done), 32'd1);
      end
      if (g == 5) chk("b2b_vip_cnt5", 32'(vip_cnt), 32'd1);
      if (g == 9) chk("b2b_vip_cnt9", 32'(vip_cnt), 32'd0);
      if (g == 13) begin
        chk("b2b_end_grant", 32'(grant), 32'd0);
        chk("b2b_end_done", 32'(svc_done), 32'd1);
      end
    end

    // Saturation: normal counter fills during a VVIP window.
    tick(3'b100);
    tick(3'b001);
    chk("sat_vvip_grant", 32'(grant), 32'b100);
    tick(3'b001);
    tick(3'b001);
    chk("sat_np_full", 32'(np_cnt), 32'd3);
    chk("sat_no_drop", 32'(drop), 32'd0);
    tick(3'b001);
    chk("sat_np_held", 32'(np_cnt), 32'd3);
    chk("sat_drop", 32'(drop), 32'd1);
    tick(3'b000);
    chk("sat_drop_end", 32'(drop), 32'd0);
    chk("sat_np_grant", 32'(grant), 32'b001);
    tick(3'b100);
    chk("vv_pend", 32'(vvip_pend), 32'd1);
    chk("vv_first_ok", 32'(drop), 32'd0);
    tick(3'b100);
    chk("vv_drop", 32'(drop), 32'd1);
    tick(3'b000);
    chk("vv_drop_end", 32'(drop), 32'd0);
    chk("vv_still_pend", 32'(vvip_pend), 32'd1);
    drain();

    // Starvation: one normal waiting, VIP arriving every cycle.
`ifdef STARVE_GUARD_EN
    exp5[0] = 3'b010; exp5[1] = 3'b010; exp5[2] = 3'b010; exp5[3] = 3'b001; exp5[4] = 3'b010;
`else
    exp5[0] = 3'b010; exp5[1] = 3'b010; exp5[2] = 3'b010; exp5[3] = 3'b010; exp5[4] = 3'b010;
`endif
    npg = 0;
    tick(3'b011);
    for (int k = 1; k <= 17; k++) begin
      tick(3'b010);
      if (k % 4 == 1) chk("guard_seq", 32'(grant), 32'(exp5[k / 4]));
      if (grant == 3'b001) npg++;
    end
`ifdef STARVE_GUARD_EN
    chk("np_served_cycles", 32'(npg), 32'd4);
`else
    chk("np_starved", 32'(npg), 32'd0);
`endif
    drain();

    // Reset in the middle of a normal customer's window.
    tick(3'b001);
    tick(3'b001);
    chk("rst_mid_grant", 32'(grant), 32'b001);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(3'b000);
      chk("post_rst_idle", 32'(grant), 32'd0);
    end

    // Randomized arrivals with occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      arr[0] = ($urandom_range(0, 99) < 45);
      arr[1] = ($urandom_range(0, 99) < 25);
      arr[2] = ($urandom_range(0, 99) < 8);
      tick(arr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_service_sched.md
Name: priority_service_sched

Overview:
- Service-window scheduler for the three customer classes the `test` block classifies: normal (np), VIP (vip) and VVIP (vvip).
- Counts pending arrivals per class and grants one shared service resource to one customer at a time.
- Each grant holds the resource for a fixed SERVICE_CYCLES window.
- Selection is strict priority VVIP > VIP > normal, with an optional starvation guard for normal customers.

Parameters:
- SERVICE_CYCLES, 4, clock cycles per service window; legal range 1..255.
- NP_W, 32, width of the normal-class pending counter.
- VIP_W, 8, width of the VIP pending counter.
- AGE_LIMIT, 3, consecutive VIP grants tolerated while normal customers wait (starvation guard only); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- np_arrive  in  1  one normal arrival this cycle.
- vip_arrive  in  1  one VIP arrival this cycle.
- vvip_arrive  in  1  one VVIP arrival this cycle.
- grant  out  3  one-hot class in service {vvip,vip,np}; 0 = idle.
- busy  out  1  high while grant != 0.
- svc_done  out  1  one-cycle pulse at the end of each service window.
- np_cnt  out  NP_W  pending normal customers.
- vip_cnt  out  VIP_W  pending VIP customers.
- vvip_pend  out  1  a VVIP customer is waiting.
- drop  out  1  one-cycle pulse: an arrival was lost to saturation.

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: grant=0, busy=0, svc_done=0, np_cnt=0, vip_cnt=0, vvip_pend=0, drop=0. Internal state: state=IDLE, timer=0, age=0.
- rst_n asserted mid-service aborts the window immediately. No svc_done pulse is issued and all pending counts are lost.

Counter update (each edge):
- cnt_next = cnt + arrive - take, where take=1 only on the edge that selects that class.
- Simultaneous arrive and take on the same class leaves the count unchanged.
- np_cnt and vip_cnt saturate at all-ones. An arrival that cannot be recorded is dropped and pulses drop on the next cycle.
- vvip_pend holds at most one customer. A vvip_arrive while vvip_pend=1 and not being taken is a drop.
- An arrival becomes visible in its count one cycle later. It is eligible for selection from the edge after that.

Selection, evaluated on the registered counts:
- If vvip_pend=1, pick VVIP.
- Else if vip_cnt!=0, pick VIP.
- Else if np_cnt!=0, pick NP.
- Else, no selection.

FSM:
- IDLE: on any edge with a pending customer: grant <= one-hot(selected class), count decremented, timer <= SERVICE_CYCLES-1, go to SERVE.
- SERVE, timer != 0: timer decrements each edge; grant is held.
- SERVE, timer == 0: svc_done <= 1 for one cycle. If a customer is pending, select back-to-back: reload timer, update grant, stay in SERVE with no idle gap. Otherwise grant <= 0 and go to IDLE.
- grant is therefore high for exactly SERVICE_CYCLES cycles per customer. Consecutive customers are seamless.
- SERVICE_CYCLES=1: every edge in SERVE is a completion edge, so each customer is held for one cycle.
- busy = (grant != 0), registered with grant.
- Arrivals during SERVE are accepted normally and counted.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - A 4-bit age counter increments on each VIP selection made while np_cnt != 0.
  - It clears on an NP selection or whenever np_cnt == 0.
  - When age == AGE_LIMIT and np_cnt != 0, NP wins over VIP, and age then clears.
  - VVIP always keeps top priority; a VVIP selection leaves age unchanged.
- Undefined: strict priority, no age register; normal customers may starve indefinitely.

Test Plan:
1. Reset mid-flight: np_arrive pulsed 2 cycles, then rst_n low while grant=001 -> all outputs 0 asynchronously (before next clk edge); after release grant stays 0 with no arrivals.
2. Priority and window: same cycle np_arrive=vip_arrive=vvip_arrive=1, SERVICE_CYCLES=4 -> grant=100 for 4 cycles, then 010 for 4, then 001 for 4, svc_done pulses 3 times, then IDLE.
3. Back-to-back plus simultaneous events: vip_cnt=1 in service, vip_arrive exactly on the completion edge -> second VIP window starts with no gap, vip_cnt returns to 0, busy never drops.
4. Saturation: with NP_W=2, 4 np_arrive pulses while a VVIP window is in service -> np_cnt=3, one drop pulse. vvip_arrive twice while vvip_pend=1 -> one drop.
5. Starvation guard (STARVE_GUARD_EN, AGE_LIMIT=3): np_cnt=1, vip_arrive every cycle -> grant sequence VIP,VIP,VIP,NP,VIP. Same stimulus without the macro -> NP is never granted.
6. Idle return: single np_arrive -> grant=001 appears 2 cycles after the arrival, lasts SERVICE_CYCLES, then busy=0 and grant=0.
